// File: rtl/jk_pkg.sv
// Shared types, excitation codes and the per-bit JK excitation function
// used by the JK excitation controller.
package jk_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_APPLY,
        ST_VERIFY,
        ST_DONE,
        ST_ERR
    } jk_ctrl_state_t;

    localparam logic [1:0] JK_HOLD   = 2'b00;
    localparam logic [1:0] JK_RESET  = 2'b01;
    localparam logic [1:0] JK_SET    = 2'b10;
    localparam logic [1:0] JK_TOGGLE = 2'b11;

    // Returns {J,K} that moves a flop from q to t in one clock.
    function automatic logic [1:0] jk_excite(input logic q, input logic t,
                                             input logic toggle_pref);
        if (q == t)
            return JK_HOLD;
        else if (toggle_pref)
            return JK_TOGGLE;
        else if (t)
            return JK_SET;
        else
            return JK_RESET;
    endfunction

endpackage

// File: rtl/jk_excitation_ctrl_if.sv
// Request/status bundle between register-programming logic and the
// JK excitation controller.
interface jk_excitation_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             req_valid;
    logic             req_ready;
    logic [WIDTH-1:0] req_target;
    logic [WIDTH-1:0] req_mask;
    logic             busy;
    logic             done;
    logic             err;
    logic [WIDTH-1:0] err_bits;

    modport master (
        output req_valid, req_target, req_mask,
        input  req_ready, busy, done, err, err_bits
    );

    modport slave (
        input  req_valid, req_target, req_mask,
        output req_ready, busy, done, err, err_bits
    );
endinterface

// File: rtl/jk_excite_bit.sv
// Combinational JK excitation encoder for one flop; unmasked bits hold.
module jk_excite_bit
    import jk_pkg::*;
#(
    parameter bit TOGGLE_PREF = 1'b0
) (
    input  logic q,
    input  logic t,
    input  logic m,
    output logic j,
    output logic k
);
    assign {j, k} = m ? jk_excite(q, t, TOGGLE_PREF) : JK_HOLD;
endmodule

// File: rtl/jk_excitation_ctrl.sv
// Drives a JK flop bank toward a requested pattern, verifies the read-back
// and retries a bounded number of times before flagging the stuck bits.
//
//   state     | meaning
//   ----------+----------------------------------------------------------
//   ST_IDLE   | ready for a request; j/k idle at 0
//   ST_APPLY  | j/k driven for exactly one clock, bank samples at the end
//   ST_VERIFY | compare q_fb against target under mask; retry or finish
//   ST_DONE   | one-cycle done pulse
//   ST_ERR    | one-cycle err pulse, err_bits holds the failing bits
module jk_excitation_ctrl
    import jk_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int MAX_RETRY   = 2,
    parameter bit TOGGLE_PREF = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    jk_excitation_ctrl_if.slave   req,
    input  logic [WIDTH-1:0]      q_fb,
    output logic [WIDTH-1:0]      j_out,
    output logic [WIDTH-1:0]      k_out
);
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [RW-1:0] RETRY_INIT = RW'(MAX_RETRY);

    jk_ctrl_state_t   state, state_nxt;
    logic [WIDTH-1:0] target_r, mask_r, err_bits_r;
    logic [WIDTH-1:0] j_r, k_r;
    logic [RW-1:0]    retry_left;

    logic [WIDTH-1:0] exc_target, exc_mask, j_exc, k_exc, mism;
    logic             accept, load_jk, retry, fail;

    // In IDLE the excitation is computed from the incoming request so it
    // can be registered on the accept edge.
    assign exc_target = (state == ST_IDLE) ? req.req_target : target_r;
    assign exc_mask   = (state == ST_IDLE) ? req.req_mask   : mask_r;
    assign mism       = (q_fb ^ target_r) & mask_r;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        jk_excite_bit #(.TOGGLE_PREF(TOGGLE_PREF)) u_bit (
            .q (q_fb[i]),
            .t (exc_target[i]),
            .m (exc_mask[i]),
            .j (j_exc[i]),
            .k (k_exc[i])
        );
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        load_jk   = 1'b0;
        retry     = 1'b0;
        fail      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req.req_valid) begin
                    accept    = 1'b1;
                    load_jk   = 1'b1;
                    state_nxt = ST_APPLY;
                end
            end
            ST_APPLY:  state_nxt = ST_VERIFY;
            ST_VERIFY: begin
                if (mism == '0) begin
                    state_nxt = ST_DONE;
                end else if (retry_left != '0) begin
                    retry     = 1'b1;
                    load_jk   = 1'b1;
                    state_nxt = ST_APPLY;
                end else begin
                    fail      = 1'b1;
                    state_nxt = ST_ERR;
                end
            end
            ST_DONE:   state_nxt = ST_IDLE;
            ST_ERR:    state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            target_r   <= '0;
            mask_r     <= '0;
            err_bits_r <= '0;
            j_r        <= '0;
            k_r        <= '0;
            retry_left <= '0;
        end else begin
            state <= state_nxt;
            j_r   <= load_jk ? j_exc : '0;
            k_r   <= load_jk ? k_exc : '0;
            if (accept) begin
                target_r   <= req.req_target;
                mask_r     <= req.req_mask;
                retry_left <= RETRY_INIT;
                err_bits_r <= '0;
            end
            if (retry)
                retry_left <= retry_left - RW'(1);
            if (fail)
                err_bits_r <= mism;
        end
    end

    assign req.req_ready = (state == ST_IDLE);
    assign req.busy      = (state != ST_IDLE);
    assign req.done      = (state == ST_DONE);
    assign req.err       = (state == ST_ERR);
    assign req.err_bits  = err_bits_r;
    assign j_out         = j_r;
    assign k_out         = k_r;

endmodule

// File: tb/tb_jk_excitation_ctrl.sv
// Directed bench: two controllers (set/reset and toggle preference) each
// driving a behavioural JK flop bank, with a stuck-at-0 injector on bank 0.
module tb_jk_excitation_ctrl;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    jk_excitation_ctrl_if #(.WIDTH(W)) ifc0 ();
    jk_excitation_ctrl_if #(.WIDTH(W)) ifc1 ();

    logic [W-1:0] bank0, bank1, q0, q1, j0, k0, j1, k1;
    logic [W-1:0] stuck0 = '0;
    logic         pre0_en = 1'b0, pre1_en = 1'b0;
    logic [W-1:0] pre0_val = '0, pre1_val = '0;

    assign q0 = bank0 & ~stuck0;
    assign q1 = bank1;

    jk_excitation_ctrl #(.WIDTH(W), .MAX_RETRY(2), .TOGGLE_PREF(1'b0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .req(ifc0.slave), .q_fb(q0), .j_out(j0), .k_out(k0));
    jk_excitation_ctrl #(.WIDTH(W), .MAX_RETRY(2), .TOGGLE_PREF(1'b1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .req(ifc1.slave), .q_fb(q1), .j_out(j1), .k_out(k1));

    always @(posedge clk) begin
        if (pre0_en) bank0 <= pre0_val;
        else for (int i = 0; i < W; i++)
            case ({j0[i], k0[i]})
                2'b01: bank0[i] <= 1'b0;
                2'b10: bank0[i] <= 1'b1;
                2'b11: bank0[i] <= ~bank0[i];
                default: ;
            endcase
        if (pre1_en) bank1 <= pre1_val;
        else for (int i = 0; i < W; i++)
            case ({j1[i], k1[i]})
                2'b01: bank1[i] <= 1'b0;
                2'b10: bank1[i] <= 1'b1;
                2'b11: bank1[i] <= ~bank1[i];
                default: ;
            endcase
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    int apply_cnt;
    logic early_flag;

    initial begin
        ifc0.req_valid = 1'b0; ifc0.req_target = '0; ifc0.req_mask = '0;
        ifc1.req_valid = 1'b0; ifc1.req_target = '0; ifc1.req_mask = '0;
        pre0_en = 1'b1; pre0_val = 8'h00;
        pre1_en = 1'b1; pre1_val = 8'hF0;
        repeat (3) @(negedge clk);
        pre0_en = 1'b0; pre1_en = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_j", j0, 8'h00);
        check("rst_k", k0, 8'h00);
        check("rst_ready", ifc0.req_ready, 1'b1);
        check("rst_busy", ifc0.busy, 1'b0);
        check("rst_done_err", {ifc0.done, ifc0.err}, 2'b00);
        check("rst_err_bits", ifc0.err_bits, 8'h00);

        // Set/reset encoding, 0x00 -> 0xA5
        ifc0.req_valid = 1'b1; ifc0.req_target = 8'hA5; ifc0.req_mask = 8'hFF;
        @(negedge clk);
        ifc0.req_valid = 1'b0;
        check("t1_apply_j", j0, 8'hA5);
        check("t1_apply_k", k0, 8'h00);
        check("t1_busy_ready", {ifc0.busy, ifc0.req_ready}, 2'b10);
        @(negedge clk);
        check("t1_verify_jk", {j0, k0}, 16'h0000);
        check("t1_bank", q0, 8'hA5);
        check("t1_no_done_yet", ifc0.done, 1'b0);
        @(negedge clk);
        check("t1_done", {ifc0.done, ifc0.err}, 2'b10);
        @(negedge clk);
        check("t1_after", {ifc0.done, ifc0.req_ready}, 2'b01);

        // Toggle preference, 0xF0 -> 0x0F
        ifc1.req_valid = 1'b1; ifc1.req_target = 8'h0F; ifc1.req_mask = 8'hFF;
        @(negedge clk);
        ifc1.req_valid = 1'b0;
        check("t2_apply_j", j1, 8'hFF);
        check("t2_apply_k", k1, 8'hFF);
        @(negedge clk);
        check("t2_bank", q1, 8'h0F);
        @(negedge clk);
        check("t2_done", {ifc1.done, ifc1.err}, 2'b10);
        @(negedge clk);

        // Partial mask, 0xFF -> low nibble cleared; second request during busy ignored
        pre0_en = 1'b1; pre0_val = 8'hFF;
        @(negedge clk);
        pre0_en = 1'b0;
        ifc0.req_valid = 1'b1; ifc0.req_target = 8'h00; ifc0.req_mask = 8'h0F;
        @(negedge clk);
        ifc0.req_target = 8'hAA; ifc0.req_mask = 8'hFF;
        check("t3_apply_j", j0, 8'h00);
        check("t3_apply_k", k0, 8'h0F);
        @(negedge clk);
        check("t3_bank", q0, 8'hF0);
        @(negedge clk);
        ifc0.req_valid = 1'b0;
        check("t3_done", ifc0.done, 1'b1);
        @(negedge clk);
        check("t3_ignored_ready", ifc0.req_ready, 1'b1);
        @(negedge clk);
        check("t3_ignored_jk", {j0, k0}, 16'h0000);
        check("t3_ignored_busy", ifc0.busy, 1'b0);
        check("t3_bank_hold", q0, 8'hF0);

        // Bit 3 stuck at 0: three applies then err
        pre0_en = 1'b1; pre0_val = 8'h00; stuck0 = 8'h08;
        @(negedge clk);
        pre0_en = 1'b0;
        ifc0.req_valid = 1'b1; ifc0.req_target = 8'h08; ifc0.req_mask = 8'hFF;
        @(negedge clk);
        ifc0.req_valid = 1'b0;
        apply_cnt = (j0 == 8'h08 && k0 == 8'h00) ? 1 : 0;
        early_flag = ifc0.err | ifc0.done;
        for (int i = 1; i < 6; i++) begin
            @(negedge clk);
            if (j0 == 8'h08 && k0 == 8'h00) apply_cnt++;
            early_flag = early_flag | ifc0.err | ifc0.done;
        end
        @(negedge clk);
        check("t4_apply_count", apply_cnt, 3);
        check("t4_no_early_pulse", early_flag, 1'b0);
        check("t4_err", {ifc0.err, ifc0.done}, 2'b10);
        check("t4_err_bits", ifc0.err_bits, 8'h08);
        @(negedge clk);
        check("t4_err_gone", {ifc0.err, ifc0.req_ready}, 2'b01);
        check("t4_err_bits_held", ifc0.err_bits, 8'h08);
        stuck0 = 8'h00;
        ifc0.req_valid = 1'b1; ifc0.req_target = 8'h08; ifc0.req_mask = 8'hFF;
        @(negedge clk);
        ifc0.req_valid = 1'b0;
        check("t4_err_bits_clr", ifc0.err_bits, 8'h00);
        check("t4_equal_jk", {j0, k0}, 16'h0000);
        repeat (2) @(negedge clk);
        check("t4_equal_done", ifc0.done, 1'b1);
        @(negedge clk);

        // Reset during APPLY aborts
        pre0_en = 1'b1; pre0_val = 8'h00;
        @(negedge clk);
        pre0_en = 1'b0;
        ifc0.req_valid = 1'b1; ifc0.req_target = 8'h3C; ifc0.req_mask = 8'hFF;
        @(negedge clk);
        ifc0.req_valid = 1'b0;
        check("t5_apply_j", j0, 8'h3C);
        #2 rst_n = 1'b0;
        #1;
        check("t5_async_jk", {j0, k0}, 16'h0000);
        check("t5_async_ready", {ifc0.req_ready, ifc0.busy}, 2'b10);
        @(negedge clk);
        rst_n = 1'b1;
        early_flag = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            early_flag = early_flag | ifc0.done | ifc0.err;
        end
        check("t5_no_pulse", early_flag, 1'b0);
        check("t5_bank_untouched", q0, 8'h00);
        ifc0.req_valid = 1'b1; ifc0.req_target = 8'h3C; ifc0.req_mask = 8'hFF;
        @(negedge clk);
        ifc0.req_valid = 1'b0;
        check("t5_new_j", j0, 8'h3C);
        repeat (2) @(negedge clk);
        check("t5_new_done", ifc0.done, 1'b1);
        check("t5_new_bank", q0, 8'h3C);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/jk_excitation_ctrl.md
# jk_excitation_ctrl

Drives the J/K inputs of a WIDTH-bit bank of JK flip-flops so the bank's outputs reach a requested target pattern. It reads back the bank's Q outputs and computes per-bit JK excitation (hold/set/reset/toggle). It then applies the excitation for one clock, verifies the result, and retries on mismatch. It sits between register-programming logic (valid/ready request side) and any JK-flop-based state bank.

## Interface
- WIDTH, 8, number of JK flops driven
- MAX_RETRY, 2, extra APPLY attempts after the first before flagging error (0 allowed)
- TOGGLE_PREF, 0, 1: changing bits use toggle (11); 0: use set (10) / reset (01)
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  1  request present
- req_ready  out  1  high only in IDLE
- req_target  in  WIDTH  desired Q pattern
- req_mask  in  WIDTH  1 = bit is controlled; 0 = bit held (J=K=0) and ignored at verify
- q_fb  in  WIDTH  Q outputs of the flop bank (same clk)
- j_out  out  WIDTH  registered J drive
- k_out  out  WIDTH  registered K drive
- busy  out  1  high when not IDLE
- done  out  1  one-cycle pulse: target reached
- err  out  1  one-cycle pulse: retries exhausted
- err_bits  out  WIDTH  masked mismatch bits at failure; held until next accept

## Operation
- States: IDLE, APPLY, VERIFY, DONE, ERR.
- IDLE: req_ready=1. On req_valid&&req_ready, capture target and mask, clear retry count, clear err_bits, and load j/k from the excitation of (q_fb, target, mask). Next state is APPLY.
- Per-bit excitation (mask=1):
  - q==t: 00.
  - q=0, t=1: 10, or 11 if TOGGLE_PREF.
  - q=1, t=0: 01, or 11 if TOGGLE_PREF.
  - mask=0 always gives 00.
- APPLY: j/k held for exactly this cycle. The flop bank samples at the closing edge. j/k are cleared to 0 at that edge. Next state is VERIFY.
- VERIFY: mism = (q_fb ^ target) & mask.
  - mism==0: next state DONE.
  - Otherwise, if retry<MAX_RETRY: retry++, reload j/k from the current q_fb, next state APPLY.
  - Otherwise: err_bits<=mism, next state ERR.
- DONE: done=1 for one cycle, then IDLE. ERR: err=1 for one cycle, then IDLE.
- j_out/k_out are 0 in every state except APPLY.
- req_valid outside IDLE is ignored; the request is not captured.
- Retry counter width is $clog2(MAX_RETRY+1).

## Timing
- Reset (asynchronous, immediate): state=IDLE, j_out=k_out=0, done=err=busy=0, err_bits=0, req_ready=1.
- Accept at edge E0. APPLY is cycle E0–E1, VERIFY is E1–E2, done is high E2–E3, and req_ready returns at E3.
- Best-case request-to-done: 2 cycles after accept. Throughput: one request per 3 cycles (accept possible at E3).
- Each retry adds 2 cycles. Worst-case err pulse starts 2·(MAX_RETRY+1) cycles after accept.
- Boundaries:
  - mask=0: j/k all 0, done at best-case latency.
  - target already equal to q_fb: j/k all 0, done at best-case latency.
  - MAX_RETRY=0: the first mismatch gives err.
  - q_fb changing from an external source during VERIFY: only the VERIFY-cycle sample counts.
  - rst_n asserted in any state aborts the operation. No done/err is produced. j/k drop to 0 asynchronously.

## Structure
- Shared package jk_pkg contains:
  - state enum jk_ctrl_state_t
  - excitation constants JK_HOLD=2'b00, JK_RESET=2'b01, JK_SET=2'b10, JK_TOGGLE=2'b11
  - function jk_excite(q, t, toggle_pref) returning 2 bits
- One natural sub-module: jk_excite_bit (combinational per-bit encoder, generated WIDTH times).
- The JK flop bank itself is outside this block. The bench instantiates WIDTH existing JK flops on clk.

## Test plan
- Reset: hold rst_n=0 for 3 cycles, release → j_out=k_out=0x00, req_ready=1, busy=0, done=err=0.
- TOGGLE_PREF=0, q_fb=0x00, target=0xA5, mask=0xFF → APPLY j=0xA5 k=0x00, bank reads 0xA5, done 2 cycles after accept, no retry.
- TOGGLE_PREF=1, q=0xF0, target=0x0F, mask=0xFF → APPLY j=k=0xFF, bank 0x0F, done.
- mask=0x0F, q=0xFF, target=0x00 → j=0x00, k=0x0F, bank ends 0xF0, done. A second req_valid during busy is ignored.
- Bench forces bit 3 stuck at 0, target=0x08, MAX_RETRY=2 → three APPLY cycles, then err pulse 6 cycles after accept, err_bits=0x08. Next accept clears err_bits.
- rst_n pulsed low during APPLY → j/k=0 immediately, no done/err, req_ready=1 after release, new request completes normally.
